// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: takes a WIDTH-bit word on a valid/ready
// handshake and sends it one bit per clock, with frame/done markers and an idle gap.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1,
  parameter int GAP       = 1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_frame,
  output logic             ser_active,
  output logic             done,
  output logic [1:0]       dbg_state
);

  // Handshake: a word transfers at a rising edge where load_valid && load_ready;
  // load_data is sampled only then, and load_valid may drop or change freely otherwise.

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [3:0]     GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [3:0]       gcnt, gcnt_n;
  logic             handshake;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= S_IDLE;
      sreg  <= '0;
      cnt   <= '0;
      gcnt  <= '0;
    end else begin
      state <= state_n;
      sreg  <= sreg_n;
      cnt   <= cnt_n;
      gcnt  <= gcnt_n;
    end
  end

  assign handshake = load_valid && load_ready;

  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    cnt_n   = cnt;
    gcnt_n  = gcnt;
    case (state)
      S_IDLE: begin
        if (handshake) begin
          sreg_n  = load_data;
          cnt_n   = CNT_LAST;
          state_n = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt == '0) begin
          // A handshake here is only possible with no gap: reload and keep shifting.
          if (handshake) begin
            sreg_n = load_data;
            cnt_n  = CNT_LAST;
          end else if (GAP > 0) begin
            state_n = S_GAP;
            gcnt_n  = GAP_LAST;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          sreg_n = (MSB_FIRST != 0) ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
          cnt_n  = cnt - CW'(1);
        end
      end
      S_GAP: begin
        if (gcnt == 4'd0) state_n = S_IDLE;
        else              gcnt_n  = gcnt - 4'd1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // All outputs decode flopped state only; nothing passes combinationally from inputs.
  assign ser_active = (state == S_SHIFT);
  assign ser_out    = ser_active && ((MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0]);
  assign ser_frame  = ser_active && (cnt == CNT_LAST);
  assign done       = ser_active && (cnt == '0);
  assign load_ready = (state == S_IDLE) || ((GAP == 0) && done);
  assign dbg_state  = state;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: three instances (MSB/gap, LSB/gap, MSB/no gap)
// checked cycle by cycle against an expected-bit queue and a loopback receiver.
module tb_piso_serializer;

  logic       clock;
  logic       clear;
  logic [3:0] ld [3];
  logic       lv [3];
  logic       lr [3];
  logic       so [3];
  logic       sf [3];
  logic       sa [3];
  logic       dn [3];
  logic [1:0] st [3];

  logic [0:0] exp_q [$];
  logic [3:0] rx;
  int total = 0;
  int bad   = 0;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1), .GAP(1)) u_msb (
    .clock(clock), .clear(clear), .load_data(ld[0]), .load_valid(lv[0]),
    .load_ready(lr[0]), .ser_out(so[0]), .ser_frame(sf[0]), .ser_active(sa[0]),
    .done(dn[0]), .dbg_state(st[0]));

  piso_serializer #(.WIDTH(4), .MSB_FIRST(0), .GAP(1)) u_lsb (
    .clock(clock), .clear(clear), .load_data(ld[1]), .load_valid(lv[1]),
    .load_ready(lr[1]), .ser_out(so[1]), .ser_frame(sf[1]), .ser_active(sa[1]),
    .done(dn[1]), .dbg_state(st[1]));

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1), .GAP(0)) u_b2b (
    .clock(clock), .clear(clear), .load_data(ld[2]), .load_valid(lv[2]),
    .load_ready(lr[2]), .ser_out(so[2]), .ser_frame(sf[2]), .ser_active(sa[2]),
    .done(dn[2]), .dbg_state(st[2]));

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // loopback receiver on the MSB-first instance
  always @(posedge clock or negedge clear) begin
    if (!clear)      rx <= 4'd0;
    else if (sa[0])  rx <= {rx[2:0], so[0]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input int d, input string tag,
                          input logic ef, input logic ed, input logic er, input logic ea);
    logic [0:0] e;
    e = 1'b0;
    if (ea) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL %s_queue observed=empty expected=bit", tag);
      end else begin
        e = exp_q.pop_front();
      end
    end
    chk($sformatf("%s_d%0d_ser_out", tag, d),    32'(so[d]), 32'(e));
    chk($sformatf("%s_d%0d_frame", tag, d),      32'(sf[d]), 32'(ef));
    chk($sformatf("%s_d%0d_done", tag, d),       32'(dn[d]), 32'(ed));
    chk($sformatf("%s_d%0d_ready", tag, d),      32'(lr[d]), 32'(er));
    chk($sformatf("%s_d%0d_active", tag, d),     32'(sa[d]), 32'(ea));
  endtask

  task automatic step(input int d, input string tag,
                      input logic ef, input logic ed, input logic er, input logic ea);
    @(negedge clock);
    chk_outs(d, tag, ef, ed, er, ea);
  endtask

  // driver: present a word and queue its bits in transmission order
  task automatic drive_word(input int d, input logic [3:0] data, input bit msb_first);
    ld[d] = data;
    lv[d] = 1'b1;
    for (int i = 0; i < 4; i++)
      exp_q.push_back(msb_first ? data[3-i] : data[i]);
  endtask

  initial begin
    clear = 1'b0;
    for (int d = 0; d < 3; d++) begin
      ld[d] = 4'd0;
      lv[d] = 1'b0;
    end

    // reset state
    @(negedge clock);
    for (int d = 0; d < 3; d++) chk_outs(d, "reset", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("reset_rx", 32'(rx), 32'd0);
    clear = 1'b1;
    @(negedge clock);

    // single word, MSB first, one gap cycle
    chk_outs(0, "single_c0", 1'b0, 1'b0, 1'b1, 1'b0);
    drive_word(0, 4'b1011, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      step(0, $sformatf("single_c%0d", c), c == 1, c == 4, 1'b0, 1'b1);
      lv[0] = 1'b0;
    end
    step(0, "single_c5", 1'b0, 1'b0, 1'b0, 1'b0);
    step(0, "single_c6", 1'b0, 1'b0, 1'b1, 1'b0);

    // LSB first
    drive_word(1, 4'b1000, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      step(1, $sformatf("lsb_c%0d", c), c == 1, c == 4, 1'b0, 1'b1);
      lv[1] = 1'b0;
    end
    step(1, "lsb_c5", 1'b0, 1'b0, 1'b0, 1'b0);
    step(1, "lsb_c6", 1'b0, 1'b0, 1'b1, 1'b0);

    // back-to-back with valid held high, no gap
    drive_word(2, 4'b1100, 1'b1);
    for (int c = 1; c <= 4; c++)
      step(2, $sformatf("b2b_c%0d", c), c == 1, c == 4, c == 4, 1'b1);
    drive_word(2, 4'b0011, 1'b1);
    for (int c = 5; c <= 8; c++) begin
      step(2, $sformatf("b2b_c%0d", c), c == 5, c == 8, c == 8, 1'b1);
      lv[2] = 1'b0;
    end
    step(2, "b2b_c9", 1'b0, 1'b0, 1'b1, 1'b0);

    // valid pulsed and data changed mid-word are ignored
    drive_word(0, 4'b1011, 1'b1);
    step(0, "hold_c1", 1'b1, 1'b0, 1'b0, 1'b1);
    lv[0] = 1'b0;
    ld[0] = 4'b0100;
    step(0, "hold_c2", 1'b0, 1'b0, 1'b0, 1'b1);
    lv[0] = 1'b1;
    ld[0] = 4'b1111;
    step(0, "hold_c3", 1'b0, 1'b0, 1'b0, 1'b1);
    ld[0] = 4'b0000;
    step(0, "hold_c4", 1'b0, 1'b1, 1'b0, 1'b1);
    lv[0] = 1'b0;
    step(0, "hold_c5", 1'b0, 1'b0, 1'b0, 1'b0);
    step(0, "hold_c6", 1'b0, 1'b0, 1'b1, 1'b0);

    // loopback into a 4-stage receiver
    drive_word(0, 4'b0110, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      step(0, $sformatf("loop_c%0d", c), c == 1, c == 4, 1'b0, 1'b1);
      lv[0] = 1'b0;
    end
    step(0, "loop_c5", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("loop_rx", 32'(rx), 32'h6);
    step(0, "loop_c6", 1'b0, 1'b0, 1'b1, 1'b0);

    // reset mid-word abandons the word
    drive_word(0, 4'b1011, 1'b1);
    step(0, "midrst_c1", 1'b1, 1'b0, 1'b0, 1'b1);
    lv[0] = 1'b0;
    step(0, "midrst_c2", 1'b0, 1'b0, 1'b0, 1'b1);
    #1 clear = 1'b0;
    exp_q.delete();
    #1 chk_outs(0, "midrst_now", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("midrst_state", 32'(st[0]), 32'd0);
    @(negedge clock);
    clear = 1'b1;
    for (int c = 1; c <= 6; c++)
      step(0, $sformatf("midrst_after_c%0d", c), 1'b0, 1'b0, 1'b1, 1'b0);

    // first handshake right after release, random data
    begin
      logic [3:0] r;
      r = 4'($urandom_range(0, 15));
      drive_word(0, r, 1'b1);
      for (int c = 1; c <= 4; c++) begin
        step(0, $sformatf("rand_c%0d", c), c == 1, c == 4, 1'b0, 1'b1);
        lv[0] = 1'b0;
      end
      step(0, "rand_c5", 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rand_rx", 32'(rx), 32'(r));
    end

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
